// File: rtl/mic_resp_demux.sv
// Return-path demux: steers tagged feature-map beats into per-core 2-entry FWFT buffers.
// Optional feature macro: MIC_DEMUX_CNT_EN adds per-core 16-bit pop counters on MIFPOL_BeatCnt.
module mic_resp_demux #(
    parameter  int POOL_CORE      = 6,
    parameter  int POOL_COMP_CORE = 64,
    parameter  int ACT_WIDTH      = 8,
    localparam int TAG_WIDTH      = $clog2(POOL_CORE),
    localparam int FM_WIDTH       = ACT_WIDTH * POOL_COMP_CORE
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [TAG_WIDTH+FM_WIDTH-1:0] MICMIF_Fm,
    input  logic                          MICMIF_FmVld,
    output logic                          MIFMIC_FmRdy,
    output logic [FM_WIDTH*POOL_CORE-1:0] MIFPOL_Fm,
    output logic [POOL_CORE-1:0]          MIFPOL_FmVld,
    input  logic [POOL_CORE-1:0]          POLMIF_FmRdy,
    output logic                          MIFPOL_TagErr
`ifdef MIC_DEMUX_CNT_EN
    ,
    output logic [16*POOL_CORE-1:0]       MIFPOL_BeatCnt
`endif
);

    logic [TAG_WIDTH-1:0] in_tag;
    logic [FM_WIDTH-1:0]  in_fm;
    logic                 tag_ok;
    logic                 tgt_full;
    logic                 acc;
    logic [POOL_CORE-1:0] push;
    logic [POOL_CORE-1:0] pop;

    logic [FM_WIDTH-1:0]  mem_q [POOL_CORE][2];
    logic [FM_WIDTH-1:0]  mem_d [POOL_CORE][2];
    logic [1:0]           cnt_q [POOL_CORE];
    logic [1:0]           cnt_d [POOL_CORE];
    logic [POOL_CORE-1:0] rd_ptr_q;
    logic [POOL_CORE-1:0] rd_ptr_d;
    logic [POOL_CORE-1:0] wr_ptr_q;
    logic [POOL_CORE-1:0] wr_ptr_d;
    logic                 tag_err_q;
    logic                 tag_err_d;

    assign in_tag = MICMIF_Fm[TAG_WIDTH+FM_WIDTH-1 -: TAG_WIDTH];
    assign in_fm  = MICMIF_Fm[FM_WIDTH-1:0];

    // Ready only looks at the addressed core's current occupancy; out-of-range tags are always taken.
    always_comb begin
        tag_ok   = (int'(in_tag) < POOL_CORE);
        tgt_full = 1'b0;
        for (int c = 0; c < POOL_CORE; c++) begin
            if (int'(in_tag) == c && cnt_q[c] == 2'd2) begin
                tgt_full = 1'b1;
            end
        end
        MIFMIC_FmRdy = ~tgt_full;
        acc          = MICMIF_FmVld & ~tgt_full;
    end

    always_comb begin
        MIFPOL_FmVld = '0;
        push         = '0;
        pop          = '0;
        for (int c = 0; c < POOL_CORE; c++) begin
            MIFPOL_FmVld[c] = (cnt_q[c] != 2'd0);
            pop[c]          = MIFPOL_FmVld[c] & POLMIF_FmRdy[c];
            push[c]         = acc & tag_ok & (int'(in_tag) == c);
        end
    end

    always_comb begin
        mem_d    = mem_q;
        cnt_d    = cnt_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        for (int c = 0; c < POOL_CORE; c++) begin
            if (push[c]) begin
                mem_d[c][wr_ptr_q[c]] = in_fm;
                wr_ptr_d[c]           = ~wr_ptr_q[c];
            end
            if (pop[c]) begin
                rd_ptr_d[c] = ~rd_ptr_q[c];
            end
            case ({push[c], pop[c]})
                2'b10:   cnt_d[c] = cnt_q[c] + 2'd1;
                2'b01:   cnt_d[c] = cnt_q[c] - 2'd1;
                default: cnt_d[c] = cnt_q[c];
            endcase
        end
        tag_err_d = tag_err_q | (acc & ~tag_ok);
    end

    always_comb begin
        MIFPOL_Fm = '0;
        for (int c = 0; c < POOL_CORE; c++) begin
            MIFPOL_Fm[FM_WIDTH*c +: FM_WIDTH] = mem_q[c][rd_ptr_q[c]];
        end
    end

    assign MIFPOL_TagErr = tag_err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < POOL_CORE; c++) begin
                mem_q[c][0] <= '0;
                mem_q[c][1] <= '0;
                cnt_q[c]    <= '0;
            end
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            tag_err_q <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            cnt_q     <= cnt_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            tag_err_q <= tag_err_d;
        end
    end

`ifdef MIC_DEMUX_CNT_EN
    logic [15:0] beat_cnt_q [POOL_CORE];
    logic [15:0] beat_cnt_d [POOL_CORE];

    // Pop counters wrap naturally at 16 bits.
    always_comb begin
        beat_cnt_d     = beat_cnt_q;
        MIFPOL_BeatCnt = '0;
        for (int c = 0; c < POOL_CORE; c++) begin
            if (pop[c]) begin
                beat_cnt_d[c] = beat_cnt_q[c] + 16'd1;
            end
            MIFPOL_BeatCnt[16*c +: 16] = beat_cnt_q[c];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < POOL_CORE; c++) begin
                beat_cnt_q[c] <= '0;
            end
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_mic_resp_demux.sv
// Self-checking bench for mic_resp_demux: directed scenarios plus randomized traffic vs a queue model.
module tb_mic_resp_demux;

    localparam int POOL_CORE      = 6;
    localparam int POOL_COMP_CORE = 64;
    localparam int ACT_WIDTH      = 8;
    localparam int TAG_WIDTH      = 3;
    localparam int FM_WIDTH       = ACT_WIDTH * POOL_COMP_CORE;

    logic                          clk = 1'b0;
    logic                          rst_n;
    logic [TAG_WIDTH+FM_WIDTH-1:0] mic_fm;
    logic                          mic_vld;
    logic                          mif_rdy;
    logic [FM_WIDTH*POOL_CORE-1:0] pol_fm;
    logic [POOL_CORE-1:0]          pol_vld;
    logic [POOL_CORE-1:0]          pol_rdy;
    logic                          tag_err;
`ifdef MIC_DEMUX_CNT_EN
    logic [16*POOL_CORE-1:0]       beat_cnt;
`endif

    always #5 clk = ~clk;

    mic_resp_demux #(
        .POOL_CORE      (POOL_CORE),
        .POOL_COMP_CORE (POOL_COMP_CORE),
        .ACT_WIDTH      (ACT_WIDTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .MICMIF_Fm      (mic_fm),
        .MICMIF_FmVld   (mic_vld),
        .MIFMIC_FmRdy   (mif_rdy),
        .MIFPOL_Fm      (pol_fm),
        .MIFPOL_FmVld   (pol_vld),
        .POLMIF_FmRdy   (pol_rdy),
        .MIFPOL_TagErr  (tag_err)
`ifdef MIC_DEMUX_CNT_EN
        ,
        .MIFPOL_BeatCnt (beat_cnt)
`endif
    );

    // Reference model: one queue per core, a sticky error bit, pop totals.
    logic [FM_WIDTH-1:0] model_q [POOL_CORE][$];
    logic                model_err;
    int                  model_pops [POOL_CORE];
    int                  n_checks;
    int                  n_pass;

    function automatic logic [FM_WIDTH-1:0] rand_fm();
        logic [FM_WIDTH-1:0] v;
        for (int i = 0; i < FM_WIDTH / 32; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic exp_rdy();
        int tag;
        tag = int'(mic_fm[TAG_WIDTH+FM_WIDTH-1 -: TAG_WIDTH]);
        if (tag >= POOL_CORE) return 1'b1;
        return model_q[tag].size() < 2;
    endfunction

    function automatic logic [POOL_CORE-1:0] exp_vld();
        logic [POOL_CORE-1:0] v;
        v = '0;
        for (int c = 0; c < POOL_CORE; c++) v[c] = (model_q[c].size() != 0);
        return v;
    endfunction

    task automatic drive(input int tag, input logic [FM_WIDTH-1:0] fm, input logic vld);
        mic_fm  = {TAG_WIDTH'(tag), fm};
        mic_vld = vld;
        #1;
    endtask

    task automatic tick();
        logic acc;
        int   tag;
        @(posedge clk);
        if (!rst_n) begin
            for (int c = 0; c < POOL_CORE; c++) begin
                model_q[c].delete();
                model_pops[c] = 0;
            end
            model_err = 1'b0;
        end else begin
            acc = mic_vld && exp_rdy();
            tag = int'(mic_fm[TAG_WIDTH+FM_WIDTH-1 -: TAG_WIDTH]);
            for (int c = 0; c < POOL_CORE; c++) begin
                if (model_q[c].size() != 0 && pol_rdy[c]) begin
                    void'(model_q[c].pop_front());
                    model_pops[c]++;
                end
            end
            if (acc) begin
                if (tag < POOL_CORE) model_q[tag].push_back(mic_fm[FM_WIDTH-1:0]);
                else model_err = 1'b1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        pol_rdy = '1;
        drive(0, '0, 1'b0);
        tick();
        tick();
        n_checks++;
        if (mif_rdy !== 1'b1) $display("[TB] FAIL reset_rdy: got %b want 1", mif_rdy); else n_pass++;
        n_checks++;
        if (pol_vld !== '0) $display("[TB] FAIL reset_vld: got %b want 0", pol_vld); else n_pass++;
        n_checks++;
        if (pol_fm !== '0) $display("[TB] FAIL reset_fm: got nonzero data, want 0"); else n_pass++;
        n_checks++;
        if (tag_err !== 1'b0) $display("[TB] FAIL reset_tagerr: got %b want 0", tag_err); else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_beat();
        logic [FM_WIDTH-1:0] pat;
        pat     = {POOL_COMP_CORE{8'hA5}};
        pol_rdy = '1;
        drive(3, pat, 1'b1);
        n_checks++;
        if (mif_rdy !== 1'b1) $display("[TB] FAIL single_rdy: got %b want 1", mif_rdy); else n_pass++;
        tick();
        drive(0, '0, 1'b0);
        n_checks++;
        if (pol_vld !== 6'b001000) $display("[TB] FAIL single_vld: got %b want 001000", pol_vld); else n_pass++;
        n_checks++;
        if (pol_fm[FM_WIDTH*3 +: FM_WIDTH] !== pat) $display("[TB] FAIL single_data: got %h want %h", pol_fm[FM_WIDTH*3 +: FM_WIDTH], pat); else n_pass++;
        tick();
        n_checks++;
        if (pol_vld !== 6'b000000) $display("[TB] FAIL single_vld_drop: got %b want 000000", pol_vld); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [FM_WIDTH-1:0] d [3];
        for (int i = 0; i < 3; i++) d[i] = rand_fm();
        pol_rdy = 6'b111011;
        drive(2, d[0], 1'b1);
        tick();
        drive(2, d[1], 1'b1);
        tick();
        drive(2, d[2], 1'b1);
        n_checks++;
        if (mif_rdy !== 1'b0) $display("[TB] FAIL bp_full_rdy: got %b want 0", mif_rdy); else n_pass++;
        tick();
        pol_rdy = '1;
        drive(2, d[2], 1'b1);
        n_checks++;
        if (pol_fm[FM_WIDTH*2 +: FM_WIDTH] !== d[0] || pol_vld[2] !== 1'b1) $display("[TB] FAIL bp_head0: vld %b data %h want 1 %h", pol_vld[2], pol_fm[FM_WIDTH*2 +: FM_WIDTH], d[0]); else n_pass++;
        n_checks++;
        if (mif_rdy !== 1'b0) $display("[TB] FAIL bp_rdy_pop: got %b want 0", mif_rdy); else n_pass++;
        tick();
        n_checks++;
        if (pol_fm[FM_WIDTH*2 +: FM_WIDTH] !== d[1] || mif_rdy !== 1'b1) $display("[TB] FAIL bp_head1: rdy %b data %h want 1 %h", mif_rdy, pol_fm[FM_WIDTH*2 +: FM_WIDTH], d[1]); else n_pass++;
        tick();
        drive(0, '0, 1'b0);
        n_checks++;
        if (pol_fm[FM_WIDTH*2 +: FM_WIDTH] !== d[2] || pol_vld[2] !== 1'b1) $display("[TB] FAIL bp_head2: vld %b data %h want 1 %h", pol_vld[2], pol_fm[FM_WIDTH*2 +: FM_WIDTH], d[2]); else n_pass++;
        tick();
        n_checks++;
        if (pol_vld !== '0) $display("[TB] FAIL bp_drained: got %b want 0", pol_vld); else n_pass++;
    endtask

    task automatic test_independence();
        logic [FM_WIDTH-1:0] e0, e1, f;
        e0 = rand_fm();
        e1 = rand_fm();
        f  = rand_fm();
        pol_rdy = 6'b111101;
        drive(1, e0, 1'b1);
        tick();
        drive(1, e1, 1'b1);
        tick();
        drive(4, f, 1'b1);
        n_checks++;
        if (mif_rdy !== 1'b1) $display("[TB] FAIL indep_rdy: got %b want 1", mif_rdy); else n_pass++;
        tick();
        drive(0, '0, 1'b0);
        n_checks++;
        if (pol_vld !== 6'b010010) $display("[TB] FAIL indep_vld: got %b want 010010", pol_vld); else n_pass++;
        n_checks++;
        if (pol_fm[FM_WIDTH*4 +: FM_WIDTH] !== f || pol_fm[FM_WIDTH*1 +: FM_WIDTH] !== e0) $display("[TB] FAIL indep_data: core4 %h core1 %h", pol_fm[FM_WIDTH*4 +: FM_WIDTH], pol_fm[FM_WIDTH*1 +: FM_WIDTH]); else n_pass++;
        tick();
        n_checks++;
        if (pol_vld !== 6'b000010) $display("[TB] FAIL indep_hold: got %b want 000010", pol_vld); else n_pass++;
        pol_rdy = '1;
        tick();
        tick();
        n_checks++;
        if (pol_vld !== '0) $display("[TB] FAIL indep_drain: got %b want 0", pol_vld); else n_pass++;
    endtask

    task automatic test_push_pop();
        logic [FM_WIDTH-1:0] d [3];
        for (int i = 0; i < 3; i++) d[i] = rand_fm();
        pol_rdy = '1;
        drive(0, d[0], 1'b1);
        tick();
        for (int i = 1; i < 3; i++) begin
            drive(0, d[i], 1'b1);
            n_checks++;
            if (mif_rdy !== 1'b1 || pol_vld !== 6'b000001 || pol_fm[FM_WIDTH-1:0] !== d[i-1]) $display("[TB] FAIL pushpop_%0d: rdy %b vld %b data %h want 1 000001 %h", i, mif_rdy, pol_vld, pol_fm[FM_WIDTH-1:0], d[i-1]); else n_pass++;
            tick();
        end
        drive(0, '0, 1'b0);
        n_checks++;
        if (pol_vld !== 6'b000001 || pol_fm[FM_WIDTH-1:0] !== d[2]) $display("[TB] FAIL pushpop_last: vld %b data %h want 000001 %h", pol_vld, pol_fm[FM_WIDTH-1:0], d[2]); else n_pass++;
        tick();
        n_checks++;
        if (pol_vld !== '0) $display("[TB] FAIL pushpop_empty: got %b want 0", pol_vld); else n_pass++;
    endtask

    task automatic test_invalid_tag();
        drive(7, rand_fm(), 1'b1);
        n_checks++;
        if (mif_rdy !== 1'b1) $display("[TB] FAIL badtag_rdy: got %b want 1", mif_rdy); else n_pass++;
        tick();
        drive(0, '0, 1'b0);
        n_checks++;
        if (pol_vld !== '0 || tag_err !== 1'b1) $display("[TB] FAIL badtag_flag: vld %b err %b want 0 1", pol_vld, tag_err); else n_pass++;
        repeat (3) tick();
        n_checks++;
        if (tag_err !== 1'b1) $display("[TB] FAIL badtag_sticky: got %b want 1", tag_err); else n_pass++;
    endtask

    task automatic test_random();
        int tag;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            tag     = ($urandom_range(0, 15) < 14) ? int'($urandom_range(0, 5)) : int'($urandom_range(6, 7));
            pol_rdy = POOL_CORE'($urandom);
            drive(tag, rand_fm(), $urandom_range(0, 3) != 0);
            n_checks++;
            if (mif_rdy !== exp_rdy()) $display("[TB] FAIL rand_rdy cyc %0d: got %b want %b", cyc, mif_rdy, exp_rdy()); else n_pass++;
            n_checks++;
            if (pol_vld !== exp_vld()) $display("[TB] FAIL rand_vld cyc %0d: got %b want %b", cyc, pol_vld, exp_vld()); else n_pass++;
            for (int c = 0; c < POOL_CORE; c++) begin
                if (model_q[c].size() != 0) begin
                    n_checks++;
                    if (pol_fm[FM_WIDTH*c +: FM_WIDTH] !== model_q[c][0]) $display("[TB] FAIL rand_data cyc %0d core %0d: got %h want %h", cyc, c, pol_fm[FM_WIDTH*c +: FM_WIDTH], model_q[c][0]); else n_pass++;
                end
`ifdef MIC_DEMUX_CNT_EN
                n_checks++;
                if (beat_cnt[16*c +: 16] !== 16'(model_pops[c])) $display("[TB] FAIL rand_cnt cyc %0d core %0d: got %0d want %0d", cyc, c, beat_cnt[16*c +: 16], 16'(model_pops[c])); else n_pass++;
`endif
            end
            n_checks++;
            if (tag_err !== model_err) $display("[TB] FAIL rand_tagerr cyc %0d: got %b want %b", cyc, tag_err, model_err); else n_pass++;
            tick();
        end
        pol_rdy = '1;
        drive(0, '0, 1'b0);
        repeat (3) tick();
    endtask

    task automatic test_reset_midstream();
        pol_rdy = 6'b011111;
        drive(5, rand_fm(), 1'b1);
        tick();
        drive(5, rand_fm(), 1'b1);
        tick();
        drive(5, rand_fm(), 1'b1);
        n_checks++;
        if (pol_vld[5] !== 1'b1 || mif_rdy !== 1'b0) $display("[TB] FAIL mid_prefill: vld5 %b rdy %b want 1 0", pol_vld[5], mif_rdy); else n_pass++;
        rst_n = 1'b0;
        tick();
        rst_n   = 1'b1;
        pol_rdy = '1;
        drive(0, '0, 1'b0);
        n_checks++;
        if (pol_vld !== '0) $display("[TB] FAIL mid_vld: got %b want 0", pol_vld); else n_pass++;
        n_checks++;
        if (mif_rdy !== 1'b1) $display("[TB] FAIL mid_rdy: got %b want 1", mif_rdy); else n_pass++;
        n_checks++;
        if (tag_err !== 1'b0) $display("[TB] FAIL mid_tagerr: got %b want 0", tag_err); else n_pass++;
`ifdef MIC_DEMUX_CNT_EN
        n_checks++;
        if (beat_cnt !== '0) $display("[TB] FAIL mid_cnt: got %h want 0", beat_cnt); else n_pass++;
`endif
        repeat (2) tick();
        n_checks++;
        if (pol_vld !== '0) $display("[TB] FAIL mid_stale: got %b want 0", pol_vld); else n_pass++;
    endtask

`ifdef MIC_DEMUX_CNT_EN
    task automatic test_beat_cnt_wrap();
        pol_rdy = '1;
        drive(0, rand_fm(), 1'b1);
        for (int i = 0; i < 65536; i++) begin
            tick();
            if (i == 1000) begin
                n_checks++;
                if (beat_cnt[15:0] !== 16'(model_pops[0])) $display("[TB] FAIL cnt_mid: got %0d want %0d", beat_cnt[15:0], 16'(model_pops[0])); else n_pass++;
            end
        end
        drive(0, '0, 1'b0);
        tick();
        n_checks++;
        if (model_pops[0] != 65536 || beat_cnt[15:0] !== 16'h0000) $display("[TB] FAIL cnt_wrap: got %0d want 0 after %0d pops", beat_cnt[15:0], model_pops[0]); else n_pass++;
    endtask
`endif

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        model_err = 1'b0;
        for (int c = 0; c < POOL_CORE; c++) model_pops[c] = 0;
        rst_n   = 1'b0;
        mic_vld = 1'b0;
        mic_fm  = '0;
        pol_rdy = '1;
        test_reset();
        test_single_beat();
        test_backpressure();
        test_independence();
        test_push_pop();
        test_invalid_tag();
        test_random();
        test_reset_midstream();
`ifdef MIC_DEMUX_CNT_EN
        test_beat_cnt_wrap();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mic_resp_demux.md
# mic_resp_demux

Return-path demultiplexer for the pooling memory interface. Consumes the tagged feature-map stream `{tag, fm}` produced by the multi-core memory-interface arbiter and steers each beat to the pool core named by its tag. Each core gets a 2-entry output buffer, so a stalled core does not drop data. The block sits between the arbiter's Fm output and the POOL_CORE pool cores' Fm inputs.

## Interface
Parameters:
- `POOL_CORE`, 6, number of pool cores / output ports
- `POOL_COMP_CORE`, 64, activations per beat
- `ACT_WIDTH`, 8, bits per activation
- Derived: `TAG_WIDTH` = `$clog2(POOL_CORE)`; `FM_WIDTH` = `ACT_WIDTH*POOL_COMP_CORE`

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `MICMIF_Fm`  in  TAG_WIDTH+FM_WIDTH  tagged beat; tag in the MSBs, fm in the LSBs
- `MICMIF_FmVld`  in  1  input beat valid
- `MIFMIC_FmRdy`  out  1  input ready
- `MIFPOL_Fm`  out  FM_WIDTH*POOL_CORE  per-core data; core c occupies `[FM_WIDTH*c +: FM_WIDTH]`
- `MIFPOL_FmVld`  out  POOL_CORE  per-core valid
- `POLMIF_FmRdy`  in  POOL_CORE  per-core ready
- `MIFPOL_TagErr`  out  1  sticky flag: a beat arrived with tag ≥ POOL_CORE

## Operation
- Each core c has a 2-entry FIFO buffer with first-word fall-through and a 2-bit occupancy count `cnt[c]` (0..2).
- Input accept: `acc = MICMIF_FmVld & MIFMIC_FmRdy`.
- `MIFMIC_FmRdy` = 1 when the tag is out of range; otherwise `(cnt[tag] != 2)`. Ready depends only on the current occupancy, not on a pop in the same cycle.
- Valid-tag accept: the beat is written to the tail of buffer[tag].
- Invalid-tag accept (tag ≥ POOL_CORE): the beat is dropped and `MIFPOL_TagErr` is set. The flag stays set until reset.
- Output: `MIFPOL_FmVld[c] = (cnt[c] != 0)`. `MIFPOL_Fm` slice c is the head entry of buffer[c].
- Pop on core c: `MIFPOL_FmVld[c] & POLMIF_FmRdy[c]`.
- Order within each core is preserved. Cores are independent: a full buffer on core c blocks only beats tagged c.
- Head-of-line blocking is accepted: while the beat at the input is tagged for a full core, no other beat is accepted.

## Timing
- Reset values: `MIFMIC_FmRdy` = 1 (all buffers empty), `MIFPOL_FmVld` = 0, `MIFPOL_Fm` = 0, `MIFPOL_TagErr` = 0, all `cnt` = 0. With `MIC_DEMUX_CNT_EN`, all beat counters = 0.
- Latency: a beat accepted at edge N shows as valid on its core in the cycle after edge N (1 cycle).
- Throughput: 1 beat/cycle when the targets are not full.
- Simultaneous push and pop on the same core:
  - `cnt` = 1: push and pop both happen, `cnt` stays 1, and the head becomes the new beat.
  - `cnt` = 2: push is impossible because ready is low.
- Data must not change on a core while `MIFPOL_FmVld[c]` = 1 and the core has not popped.
- Valid-beat pointers wrap modulo 2.
- Reset mid-stream: `rst_n` = 0 sampled at an edge flushes all buffers, drops in-flight beats, and clears all state in that same edge.

## Configuration
- `MIC_DEMUX_CNT_EN` defined: adds `MIFPOL_BeatCnt`, out, `16*POOL_CORE` bits.
  - Slice c is a 16-bit count of pops on core c.
  - Wraps from 0xFFFF to 0.
  - Cleared by reset.
- Not defined: the port and its counters do not exist; the rest of the behaviour is identical.

## Test plan
- Single beat: POOL_CORE=6, input tag 3, fm = 0xA5 repeated, `POLMIF_FmRdy` = all ones -> `MIFPOL_FmVld` = 6'b001000 for exactly 1 cycle, one cycle after acceptance, and slice 3 = 0xA5 pattern.
- Backpressure: `POLMIF_FmRdy[2]` = 0; send 3 beats tagged 2 (D0, D1, D2) -> D0 and D1 accepted; `MIFMIC_FmRdy` = 0 holding D2. Raise ready[2] -> pops D0, D1, D2 in order; no loss.
- Independence: core 1 full and stalled; next beat tagged 4 after core-1 beats already drained from the input -> tag-4 beat delivered in 1 cycle while core 1 holds 2 entries.
- Simultaneous push and pop at `cnt` = 1 on core 0 -> `cnt` stays 1; sequence D0 then D1 is preserved over back-to-back cycles.
- Invalid tag 7 (POOL_CORE=6) -> beat accepted, no `MIFPOL_FmVld` bit rises, `MIFPOL_TagErr` = 1 until reset.
- Reset mid-stream with 2 entries buffered on core 5 -> after the reset edge `MIFPOL_FmVld` = 0, `MIFMIC_FmRdy` = 1, `MIFPOL_TagErr` = 0. With `MIC_DEMUX_CNT_EN`, the counters are 0, and 65536 pops on core 0 give slice 0 = 0.
